// File: rtl/gpio_control_wb_pkg.sv
// Shared definitions for the GPIO-control Wishbone initiator: FSM states,
// response status codes and the register map the sequencer tests target.
package gpio_control_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_TIMEOUT  = 2'b01;
   localparam logic [1:0] ST_MISALIGN = 2'b10;

   // GPIO-control slave register map (byte offsets from the slave base)
   localparam logic [31:0] GPIO_CTRL_BASE   = 32'h3000_0000;
   localparam logic [31:0] REG_ID_OFS       = 32'h0000_0000;
   localparam logic [31:0] REG_PIN_SEL_OFS  = 32'h0000_0004;
   localparam logic [31:0] REG_OEB_MUX_OFS  = 32'h0000_0008;
   localparam logic [31:0] REG_STATUS_OFS   = 32'h0000_000C;

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating bus-timeout counter. MAX_CYCLES=0 disables expiry entirely.
module wb_timeout_counter #(
   parameter int MAX_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);
   localparam logic [W-1:0] TOP  = W'(MAX_CYCLES);
   localparam logic [W-1:0] LAST = (MAX_CYCLES == 0) ? '0 : W'(MAX_CYCLES - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (enable && (cnt != TOP)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Expiry fires while the last allowed wait cycle is in progress
   assign expired = (MAX_CYCLES != 0) && (cnt == LAST);

endmodule

// File: rtl/gpio_control_wb_master.sv
// Wishbone classic initiator: one command in, one single read/write cycle on the
// bus, one response out, with a timeout guard against a slave that never acks.
module gpio_control_wb_master
   import gpio_control_wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ADR_W          = 32,
   parameter int DAT_W          = 32
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic               cmd_we_i,
   input  logic [ADR_W-1:0]   cmd_adr_i,
   input  logic [DAT_W-1:0]   cmd_dat_i,
   input  logic [DAT_W/8-1:0] cmd_sel_i,
   output logic               wbm_cyc_o,
   output logic               wbm_stb_o,
   output logic               wbm_we_o,
   output logic [ADR_W-1:0]   wbm_adr_o,
   output logic [DAT_W-1:0]   wbm_dat_o,
   output logic [DAT_W/8-1:0] wbm_sel_o,
   input  logic [DAT_W-1:0]   wbm_dat_i,
   input  logic               wbm_ack_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [DAT_W-1:0]   rsp_dat_o,
   output logic [1:0]         rsp_status_o,
   output logic [1:0]         dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both
   // high; valid never waits on ready, and payload is held stable while valid is high.

   state_t state;
   logic   cnt_clear;
   logic   cnt_en;
   logic   timed_out;

   assign cmd_ready_o = (state == IDLE);
   assign dbg_state_o = state;
   assign cnt_clear   = (state == IDLE);
   assign cnt_en      = (state == BUS) && !wbm_ack_i;

   wb_timeout_counter #(
      .MAX_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .clear   (cnt_clear),
      .enable  (cnt_en),
      .expired (timed_out)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state        <= IDLE;
         wbm_cyc_o    <= 1'b0;
         wbm_stb_o    <= 1'b0;
         wbm_we_o     <= 1'b0;
         wbm_adr_o    <= '0;
         wbm_dat_o    <= '0;
         wbm_sel_o    <= '0;
         rsp_valid_o  <= 1'b0;
         rsp_dat_o    <= '0;
         rsp_status_o <= ST_OK;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  if (cmd_adr_i[1:0] != 2'b00) begin
                     // Misaligned: answer directly, the bus is never touched
                     rsp_valid_o  <= 1'b1;
                     rsp_dat_o    <= '0;
                     rsp_status_o <= ST_MISALIGN;
                     state        <= RESP;
                  end else begin
                     wbm_we_o  <= cmd_we_i;
                     wbm_adr_o <= cmd_adr_i;
                     wbm_dat_o <= cmd_dat_i;
                     wbm_sel_o <= cmd_sel_i;
                     wbm_cyc_o <= 1'b1;
                     wbm_stb_o <= 1'b1;
                     state     <= BUS;
                  end
               end
            end
            BUS: begin
               // Ack takes priority over a timeout expiring in the same cycle
               if (wbm_ack_i) begin
                  wbm_cyc_o    <= 1'b0;
                  wbm_stb_o    <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_dat_o    <= wbm_we_o ? '0 : wbm_dat_i;
                  rsp_status_o <= ST_OK;
                  state        <= RESP;
               end else if (timed_out) begin
                  wbm_cyc_o    <= 1'b0;
                  wbm_stb_o    <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_dat_o    <= '0;
                  rsp_status_o <= ST_TIMEOUT;
                  state        <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               wbm_cyc_o   <= 1'b0;
               wbm_stb_o   <= 1'b0;
               rsp_valid_o <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_control_wb_master.sv
// Directed bench for gpio_control_wb_master: write, read, timeout, misaligned,
// backpressure, ack/timeout collision and reset in the middle of a bus cycle.
module tb_gpio_control_wb_master;
   import gpio_control_wb_pkg::*;

   localparam int ADR_W = 32;
   localparam int DAT_W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic               cmd_we    = 1'b0;
   logic [ADR_W-1:0]   cmd_adr   = '0;
   logic [DAT_W-1:0]   cmd_dat   = '0;
   logic [DAT_W/8-1:0] cmd_sel   = '0;
   logic               wbm_cyc, wbm_stb, wbm_we;
   logic [ADR_W-1:0]   wbm_adr;
   logic [DAT_W-1:0]   wbm_dat_o;
   logic [DAT_W/8-1:0] wbm_sel;
   logic [DAT_W-1:0]   wbm_dat_i = '0;
   logic               wbm_ack   = 1'b0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [DAT_W-1:0]   rsp_dat;
   logic [1:0]         rsp_status;
   logic [1:0]         dbg_state;

   gpio_control_wb_master #(
      .TIMEOUT_CYCLES (8),
      .ADR_W          (ADR_W),
      .DAT_W          (DAT_W)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_we_i     (cmd_we),
      .cmd_adr_i    (cmd_adr),
      .cmd_dat_i    (cmd_dat),
      .cmd_sel_i    (cmd_sel),
      .wbm_cyc_o    (wbm_cyc),
      .wbm_stb_o    (wbm_stb),
      .wbm_we_o     (wbm_we),
      .wbm_adr_o    (wbm_adr),
      .wbm_dat_o    (wbm_dat_o),
      .wbm_sel_o    (wbm_sel),
      .wbm_dat_i    (wbm_dat_i),
      .wbm_ack_i    (wbm_ack),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_dat_o    (rsp_dat),
      .rsp_status_o (rsp_status),
      .dbg_state_o  (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [33:0] exp_q[$];   // {status, data} of each expected response

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance one edge; outputs are then sampled 1ns after it and inputs changed there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_cmd(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
   endtask

   task automatic drop_cmd();
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_adr   = '0;
      cmd_dat   = '0;
      cmd_sel   = '0;
   endtask

   // Consume the pending response and compare it with the scoreboard head.
   task automatic take_rsp(input string tag);
      logic [33:0] exp;
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s_sb_empty observed=response expected=none", tag);
      end else begin
         exp = exp_q.pop_front();
         check({tag, "_rsp_status"}, 64'(rsp_status), 64'(exp[33:32]));
         check({tag, "_rsp_dat"},    64'(rsp_dat),    64'(exp[31:0]));
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin : stim
      int cyc_cnt;

      // Reset state
      repeat (2) tick();
      check("rst_cyc",       64'(wbm_cyc),    64'd0);
      check("rst_stb",       64'(wbm_stb),    64'd0);
      check("rst_rsp_valid", 64'(rsp_valid),  64'd0);
      check("rst_state",     64'(dbg_state),  64'(IDLE));
      check("rst_ready",     64'(cmd_ready),  64'd1);
      check("rst_adr",       64'(wbm_adr),    64'd0);
      check("rst_status",    64'(rsp_status), 64'd0);
      check("rst_rsp_dat",   64'(rsp_dat),    64'd0);
      rst = 1'b0;
      tick();

      // 1: write to pin-select, slave acks on the second stb cycle
      put_cmd(1'b1, 32'h3000_0004, 32'h0000_00A5, 4'hF);
      check("wr_ready_idle", 64'(cmd_ready), 64'd1);
      exp_q.push_back({2'b00, 32'h0000_0000});
      tick();
      drop_cmd();
      check("wr_cyc",   64'(wbm_cyc),   64'd1);
      check("wr_stb",   64'(wbm_stb),   64'd1);
      check("wr_we",    64'(wbm_we),    64'd1);
      check("wr_adr",   64'(wbm_adr),   64'h3000_0004);
      check("wr_dat",   64'(wbm_dat_o), 64'h0000_00A5);
      check("wr_sel",   64'(wbm_sel),   64'hF);
      check("wr_busy",  64'(cmd_ready), 64'd0);
      check("wr_state", 64'(dbg_state), 64'(BUS));
      tick();
      check("wr_cyc_wait", 64'(wbm_cyc),   64'd1);
      check("wr_no_rsp",   64'(rsp_valid), 64'd0);
      wbm_ack = 1'b1;
      tick();
      wbm_ack = 1'b0;
      check("wr_cyc_drop", 64'(wbm_cyc), 64'd0);
      check("wr_stb_drop", 64'(wbm_stb), 64'd0);
      take_rsp("wr");
      tick();
      check("wr_single_rsp", 64'(rsp_valid), 64'd0);

      // 2: read with ack on the first stb cycle (minimum latency), then
      // 5: backpressure while the next command waits
      put_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
      wbm_dat_i = 32'hDEAD_BEEF;
      exp_q.push_back({2'b00, 32'hDEAD_BEEF});
      tick();
      drop_cmd();
      check("rd_cyc", 64'(wbm_cyc), 64'd1);
      check("rd_we",  64'(wbm_we),  64'd0);
      check("rd_adr", 64'(wbm_adr), 64'h3000_0008);
      wbm_ack = 1'b1;
      tick();
      wbm_ack   = 1'b0;
      wbm_dat_i = 32'h0;
      check("rd_cyc_drop", 64'(wbm_cyc),   64'd0);
      check("rd_rsp_fast", 64'(rsp_valid), 64'd1);
      put_cmd(1'b0, 32'h3000_0006, 32'h0, 4'hF);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid",  64'(rsp_valid),  64'd1);
         check("bp_dat",    64'(rsp_dat),    64'hDEAD_BEEF);
         check("bp_status", 64'(rsp_status), 64'd0);
         check("bp_ready",  64'(cmd_ready),  64'd0);
      end
      take_rsp("rd");
      // handshake edge must not have consumed the waiting command
      check("bp_idle_after", 64'(dbg_state), 64'(IDLE));
      check("bp_ready_after", 64'(cmd_ready), 64'd1);

      // 4: misaligned command is accepted now and answered without a bus cycle
      exp_q.push_back({2'b10, 32'h0000_0000});
      tick();
      drop_cmd();
      check("mis_cyc",   64'(wbm_cyc),   64'd0);
      check("mis_state", 64'(dbg_state), 64'(RESP));
      take_rsp("mis");
      check("mis_cyc_after", 64'(wbm_cyc), 64'd0);

      // 3: timeout, slave never acks
      put_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF);
      exp_q.push_back({2'b01, 32'h0000_0000});
      tick();
      drop_cmd();
      cyc_cnt = wbm_cyc ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         if (!wbm_cyc) break;
         tick();
         if (wbm_cyc) cyc_cnt++;
      end
      check("to_cyc_cycles", 64'(cyc_cnt), 64'd8);
      check("to_stb", 64'(wbm_stb), 64'd0);
      take_rsp("to");

      // ack arrives in the same cycle the timeout would fire: ack wins
      put_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF);
      exp_q.push_back({2'b00, 32'h1234_5678});
      tick();
      drop_cmd();
      repeat (7) tick();
      check("race_cyc", 64'(wbm_cyc), 64'd1);
      wbm_ack   = 1'b1;
      wbm_dat_i = 32'h1234_5678;
      tick();
      wbm_ack   = 1'b0;
      wbm_dat_i = 32'h0;
      take_rsp("race");

      // 6: reset while the bus cycle is open; a late ack is ignored
      put_cmd(1'b1, 32'h3000_0004, 32'h0000_0011, 4'h1);
      tick();
      drop_cmd();
      check("rb_cyc", 64'(wbm_cyc), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rb_cyc",       64'(wbm_cyc),   64'd0);
      check("rb_stb",       64'(wbm_stb),   64'd0);
      check("rb_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rb_state",     64'(dbg_state), 64'(IDLE));
      wbm_ack = 1'b1;
      tick();
      wbm_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("rb_late_ack_rsp", 64'(rsp_valid), 64'd0);
         check("rb_late_ack_cyc", 64'(wbm_cyc),   64'd0);
         tick();
      end
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time guard so a broken DUT can never hang the run
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
